// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared states, glyph constants and helpers for the seven-segment scanner
package seg_pkg;

  localparam int NDIG = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Index of the most significant nonzero nibble; invalid nibbles count as
  // nonzero so an error glyph is never blanked. An all-zero word yields 0.
  function automatic logic [2:0] find_msd(input logic [4*NDIG-1:0] v);
    logic [2:0] m;
    m = 3'd0;
    for (int k = 0; k < NDIG; k++) begin
      if (v[4*k +: 4] != 4'h0) m = 3'(k);
    end
    return m;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// rtl/seg_decoder.sv - nibble to active-low seven-segment glyph, 'E' for non-decimal
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // Decimal digits map to their glyphs; 10-15 fall back to the error glyph
  always_comb begin
    glyph = SEG_E;
    case (nibble)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_E;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - 8-digit multiplexed common-anode display scanner with tear-free updates
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int CLK_DIV    = 50000,
  parameter int GAP_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] bcd,
  input  logic        neg,
  output logic [6:0]  segs,
  output logic [7:0]  dig_sel,
  output logic        frame_start,
  output logic        sign_ovf
);

  // One shared phase counter serves both DRIVE and GAP, sized for the longer
  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   shadow_bcd_q, shadow_bcd_d;
  logic          shadow_neg_q, shadow_neg_d;
  logic [31:0]   active_bcd_q, active_bcd_d;
  logic          active_neg_q, active_neg_d;
  logic          sign_ovf_q, sign_ovf_d;
  logic [6:0]    segs_q, segs_d;
  logic [7:0]    dig_sel_q, dig_sel_d;
  logic          frame_start_q, frame_start_d;

  logic [2:0]    msd;
  logic [3:0]    cur_nibble;
  logic [6:0]    dec_glyph;
  logic [6:0]    glyph;

  assign msd        = find_msd(active_bcd_q);
  assign cur_nibble = active_bcd_q[{idx_q, 2'b00} +: 4];

  seg_decoder u_dec (
    .nibble (cur_nibble),
    .glyph  (dec_glyph)
  );

  // Glyph for the digit under scan: blank above msd, minus just above msd
  always_comb begin
    glyph = dec_glyph;
    if (idx_q > msd) begin
      glyph = SEG_BLANK;
      if (active_neg_q && ({1'b0, idx_q} == ({1'b0, msd} + 4'd1))) begin
        glyph = SEG_MINUS;
      end
    end
  end

  // Next-state: scan FSM, shadow capture, frame-boundary active update
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_neg_d = shadow_neg_q;
    active_bcd_d = active_bcd_q;
    active_neg_d = active_neg_q;

    if (load) begin
      shadow_bcd_d = bcd;
      shadow_neg_d = neg;
    end

    case (state_q)
      IDLE: begin
        if (load) begin
          active_bcd_d = bcd;
          active_neg_d = neg;
          state_d      = DRIVE;
          idx_d        = 3'd0;
          cnt_d        = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = DRIVE;
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          // Wrap 7 -> 0 is the frame boundary; a load on this very edge
          // only reaches the shadow, so the old shadow is taken here.
          if (idx_q == 3'd7) begin
            active_bcd_d = shadow_bcd_q;
            active_neg_d = shadow_neg_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
        cnt_d   = '0;
      end
    endcase

    sign_ovf_d = active_neg_d && (active_bcd_d[31:28] != 4'h0);
  end

  // Registered pin drive, derived from the current scan position
  always_comb begin
    segs_d        = SEG_BLANK;
    dig_sel_d     = 8'hFF;
    frame_start_d = 1'b0;
    if (state_q == DRIVE) begin
      segs_d        = glyph;
      dig_sel_d     = ~(8'h01 << idx_q);
      frame_start_d = (idx_q == 3'd0) && (cnt_q == '0);
    end
  end

  // State and output registers with immediate blanking on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= 3'd0;
      cnt_q         <= '0;
      shadow_bcd_q  <= '0;
      shadow_neg_q  <= 1'b0;
      active_bcd_q  <= '0;
      active_neg_q  <= 1'b0;
      sign_ovf_q    <= 1'b0;
      segs_q        <= SEG_BLANK;
      dig_sel_q     <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      shadow_bcd_q  <= shadow_bcd_d;
      shadow_neg_q  <= shadow_neg_d;
      active_bcd_q  <= active_bcd_d;
      active_neg_q  <= active_neg_d;
      sign_ovf_q    <= sign_ovf_d;
      segs_q        <= segs_d;
      dig_sel_q     <= dig_sel_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign segs        = segs_q;
  assign dig_sel     = dig_sel_q;
  assign frame_start = frame_start_q;
  assign sign_ovf    = sign_ovf_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - self-checking bench for seven_seg_scanner
module tb_seven_seg_scanner;

  logic        clock;
  logic        reset;
  logic        load;
  logic [31:0] bcd;
  logic        neg;
  logic [6:0]  segs;
  logic [7:0]  dig_sel;
  logic        frame_start;
  logic        sign_ovf;

  int checks;
  int failures;

  seven_seg_scanner #(
    .CLK_DIV    (4),
    .GAP_CYCLES (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .bcd         (bcd),
    .neg         (neg),
    .segs        (segs),
    .dig_sel     (dig_sel),
    .frame_start (frame_start),
    .sign_ovf    (sign_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] bcd;
    logic        neg;
    logic [55:0] exp;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Wait for frame_start, then check one full 48-cycle frame digit by digit
  task automatic check_frame(input string nm, input logic [55:0] exp, output int waited);
    int         n;
    logic       ok;
    logic [7:0] es;
    logic [6:0] eg;
    logic [7:0] bad_sel;
    logic [6:0] bad_seg;
    logic [7:0] bad_es;
    logic [6:0] bad_eg;
    n = 0;
    while (!frame_start && n < 200) begin
      @(negedge clock);
      n++;
    end
    waited = n;
    checks++;
    if (!frame_start) begin
      failures++;
      $display("FAIL %s_frame_start: got timeout expected pulse", nm);
      return;
    end
    for (int d = 0; d < 8; d++) begin
      ok = 1'b1;
      bad_sel = 8'h00; bad_seg = 7'h00; bad_es = 8'h00; bad_eg = 7'h00;
      for (int c = 0; c < 6; c++) begin
        es = (c < 4) ? ~(8'h01 << d) : 8'hFF;
        eg = (c < 4) ? exp[7*d +: 7] : 7'h7F;
        if ((dig_sel !== es || segs !== eg) && ok) begin
          ok = 1'b0;
          bad_sel = dig_sel; bad_seg = segs; bad_es = es; bad_eg = eg;
        end
        @(negedge clock);
      end
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL %s_digit%0d: got sel=%h segs=%h expected sel=%h segs=%h",
                 nm, d, bad_sel, bad_seg, bad_es, bad_eg);
      end
    end
    chk({nm, "_period48"}, 64'(frame_start), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    load  = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulse_load(input logic [31:0] v, input logic s);
    bcd  = v;
    neg  = s;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
  endtask

  initial begin
    int w;
    int n;
    logic torn;
    checks   = 0;
    failures = 0;
    reset = 1'b0; load = 1'b0; bcd = '0; neg = 1'b0;

    vecs[0] = '{"v105",   32'h00000105, 1'b0,
                {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h79,7'h40,7'h12}, 1'b0};
    vecs[1] = '{"v42neg", 32'h00000042, 1'b1,
                {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h3F,7'h19,7'h24}, 1'b0};
    vecs[2] = '{"vfull",  32'h12345678, 1'b1,
                {7'h79,7'h24,7'h30,7'h19,7'h12,7'h02,7'h78,7'h00}, 1'b1};
    vecs[3] = '{"vzero",  32'h00000000, 1'b0,
                {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40}, 1'b0};
    vecs[4] = '{"v3A",    32'h0000003A, 1'b0,
                {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h30,7'h06}, 1'b0};
    vecs[5] = '{"vnegz",  32'h00000000, 1'b1,
                {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h3F,7'h40}, 1'b0};
    vecs[6] = '{"vFtop",  32'hF0000000, 1'b0,
                {7'h06,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40}, 1'b0};
    vecs[7] = '{"v8at6",  32'h08000000, 1'b1,
                {7'h3F,7'h00,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40}, 1'b0};

    #1 reset = 1'b1;
    #2;
    chk("rst_segs",    64'(segs),        64'h7F);
    chk("rst_dig_sel", 64'(dig_sel),     64'hFF);
    chk("rst_fs",      64'(frame_start), 64'd0);
    chk("rst_ovf",     64'(sign_ovf),    64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Table: load from IDLE, check latency, one whole frame and sign_ovf
    for (int i = 0; i < 8; i++) begin
      do_reset();
      pulse_load(vecs[i].bcd, vecs[i].neg);
      chk({vecs[i].name, "_lat_off"}, 64'(dig_sel), 64'hFF);
      check_frame(vecs[i].name, vecs[i].exp, w);
      chk({vecs[i].name, "_lat_on"}, 64'(w), 64'd1);
      chk({vecs[i].name, "_ovf"}, 64'(sign_ovf), 64'(vecs[i].ovf));
    end

    // Async reset in the middle of digit 3's drive phase
    do_reset();
    pulse_load(32'h12345678, 1'b1);
    n = 0;
    while (!frame_start && n < 200) begin @(negedge clock); n++; end
    chk("mid_fs_seen", 64'(frame_start), 64'd1);
    repeat (19) @(negedge clock);
    chk("mid_pre_sel", 64'(dig_sel), 64'hF7);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_segs", 64'(segs),     64'h7F);
    chk("mid_rst_sel",  64'(dig_sel),  64'hFF);
    chk("mid_rst_ovf",  64'(sign_ovf), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    torn = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (dig_sel !== 8'hFF || frame_start !== 1'b0) torn = 1'b1;
    end
    chk("idle_hold", 64'(torn), 64'd0);

    // Two loads mid-frame: current frame untouched, next frame shows the last
    do_reset();
    pulse_load(32'h00000005, 1'b0);
    check_frame("tear_pre", {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h12}, w);
    repeat (10) @(negedge clock);
    pulse_load(32'h00000011, 1'b0);
    repeat (8) @(negedge clock);
    pulse_load(32'h00000022, 1'b0);
    torn = 1'b0;
    n = 0;
    while (!frame_start && n < 100) begin
      if (dig_sel !== 8'hFF && segs !== 7'h7F) torn = 1'b1;
      @(negedge clock);
      n++;
    end
    chk("tear_cur_frame", 64'(torn), 64'd0);
    check_frame("tear_new", {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h24,7'h24}, w);

    // Load coinciding with the frame-boundary edge lands one frame later
    repeat (46) @(negedge clock);
    pulse_load(32'h00000033, 1'b0);
    check_frame("bnd_old", {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h24,7'h24}, w);
    check_frame("bnd_new", {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h30,7'h30}, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
